// File: rtl/dircc_processing_mem_reader.sv
// Avalon-MM read master for the 16-bit processing-memory port. It streams a command's halfwords out as an Avalon-ST packet.
// Optional feature: define DIRCC_MEM_READER_CHECKSUM_EN to add a 16-bit XOR checksum output.
module dircc_processing_mem_reader #(
    parameter int MEM_WORDS  = 15000,
    parameter int ADDR_W     = 14,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    input  logic [15:0]       mem_readdata,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [15:0]       st_data,
    output logic              st_sop,
    output logic              st_eop,
`ifdef DIRCC_MEM_READER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C   = FIFO_DEPTH[CNT_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e            state_q;
    logic              cmd_ready_q;
    logic              chipselect_q;
    logic              rd_pend_q;
    logic              zero_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  issue_left_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  push_cnt_q;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [15:0]       fifo_data_q [FIFO_DEPTH];
    logic              fifo_sop_q  [FIFO_DEPTH];
    logic              fifo_eop_q  [FIFO_DEPTH];

    logic              accept;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              credit;
    logic              issue_next;
    logic [CNT_W:0]    occ_sum;
    logic [ADDR_W-1:0] addr_d;

    assign accept   = cmd_valid & cmd_ready_q;
    assign push     = rd_pend_q;
    assign st_valid = (count_q != '0);
    assign pop      = st_valid & st_ready;
    assign last_pop = pop & fifo_eop_q[rd_ptr_q] & (state_q == DRAIN);

    // Words issued but not yet popped; a same-cycle pop frees a slot for the next issue.
    assign occ_sum    = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pend_q} + {{CNT_W{1'b0}}, chipselect_q};
    assign credit     = (occ_sum - {{CNT_W{1'b0}}, pop}) < DEPTH_C;
    assign issue_next = (state_q == READ) && (issue_left_q != '0) && credit;
    assign addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    assign cmd_ready      = cmd_ready_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = chipselect_q;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign st_data        = fifo_data_q[rd_ptr_q];
    assign st_sop         = st_valid & fifo_sop_q[rd_ptr_q];
    assign st_eop         = st_valid & fifo_eop_q[rd_ptr_q];
    assign done           = zero_done_q | last_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            chipselect_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            zero_done_q  <= 1'b0;
            addr_q       <= '0;
            issue_left_q <= '0;
            len_q        <= '0;
            push_cnt_q   <= '0;
        end else begin
            rd_pend_q   <= chipselect_q;
            zero_done_q <= 1'b0;
            if (chipselect_q) addr_q <= addr_d;
            if (push) push_cnt_q <= push_cnt_q + LEN_W'(1);
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        len_q      <= cmd_len;
                        push_cnt_q <= '0;
                        addr_q     <= cmd_addr;
                        if (cmd_len == '0) begin
                            zero_done_q <= 1'b1;
                        end else begin
                            state_q      <= READ;
                            cmd_ready_q  <= 1'b0;
                            chipselect_q <= 1'b1;
                            issue_left_q <= cmd_len - LEN_W'(1);
                        end
                    end
                end
                READ: begin
                    chipselect_q <= issue_next;
                    if (issue_next) issue_left_q <= issue_left_q - LEN_W'(1);
                    if (issue_left_q == '0) state_q <= DRAIN;
                end
                DRAIN: begin
                    chipselect_q <= 1'b0;
                    if (last_pop) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet markers are attached at push time so they travel with their word through any stall.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_readdata;
            fifo_sop_q[wr_ptr_q]  <= (push_cnt_q == '0);
            fifo_eop_q[wr_ptr_q]  <= (push_cnt_q == len_q - LEN_W'(1));
        end
    end

`ifdef DIRCC_MEM_READER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q ^ st_data;
        end
    end

    assign checksum = pop ? (csum_q ^ st_data) : csum_q;
`endif

endmodule

// File: tb/tb_dircc_processing_mem_reader.sv
// Self-checking bench for dircc_processing_mem_reader: vector table, corner-case sequences and random commands.
// Checksum checks are compiled in when DIRCC_MEM_READER_CHECKSUM_EN is defined.
module tb_dircc_processing_mem_reader;

    localparam int MEM_WORDS = 15000;
    localparam int DEPTH     = 4;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [13:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_data;
    logic        st_sop;
    logic        st_eop;
    logic        done;
`ifdef DIRCC_MEM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [MEM_WORDS];

    dircc_processing_mem_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_data        (st_data),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
`ifdef DIRCC_MEM_READER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the chipselect cycle.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Runs one command; mode 0 = st_ready high, 1 = 1-0-0-1 pattern, 2 = random.
    // stopAfter >= 0 returns early once that many words have been popped.
    task automatic applyStimulus(input int addr, input int len, input int mode, input int stopAfter,
                                 output logic [15:0] firstData, output logic [15:0] lastData);
        int issued, popped, firstValidK, budget, waitCnt;
        logic sawDone, stallPrev, heldSop, heldEop;
        logic [15:0] heldData, expWord, expCsum;
        issued = 0; popped = 0; firstValidK = -1; waitCnt = 0;
        sawDone = 1'b0; stallPrev = 1'b0; heldSop = 1'b0; heldEop = 1'b0;
        heldData = '0; expCsum = '0; firstData = '0; lastData = '0;
        budget = 100 + 8 * len;
        @(negedge clk);
        while (!cmd_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = 14'(addr);
        cmd_len   = 8'(len);
        for (int k = 0; k < budget && !sawDone; k++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            case (mode)
                0:       st_ready = 1'b1;
                1:       st_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: st_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (mem_chipselect) begin
                checkOutput("mem_address", 32'(mem_address), 32'((addr + issued) % MEM_WORDS));
                issued++;
                checkOutput("outstanding_le_depth", 32'((issued - popped) <= DEPTH), 32'd1);
            end
            if (stallPrev) begin
                checkOutput("stall_valid", 32'(st_valid), 32'd1);
                checkOutput("stall_data", 32'(st_data), 32'(heldData));
                checkOutput("stall_marks", 32'({st_sop, st_eop}), 32'({heldSop, heldEop}));
            end
            if (st_valid && firstValidK < 0) firstValidK = k;
            if (st_valid && st_ready) begin
                expWord = mem[(addr + popped) % MEM_WORDS];
                checkOutput("st_data", 32'(st_data), 32'(expWord));
                checkOutput("st_sop", 32'(st_sop), 32'(popped == 0));
                checkOutput("st_eop", 32'(st_eop), 32'(popped == len - 1));
                checkOutput("done_with_last_pop", 32'(done), 32'(popped == len - 1));
                if (popped == 0) firstData = st_data;
                lastData = st_data;
                expCsum  = expCsum ^ expWord;
                popped++;
`ifdef DIRCC_MEM_READER_CHECKSUM_EN
                if (popped == len) checkOutput("checksum", 32'(checksum), 32'(expCsum));
`endif
            end else if (done) begin
                checkOutput("done_zero_len_timing", 32'(len == 0 && k == 0), 32'd1);
`ifdef DIRCC_MEM_READER_CHECKSUM_EN
                checkOutput("checksum_zero_len", 32'(checksum), 32'd0);
`endif
            end
            if (done) sawDone = 1'b1;
            stallPrev = st_valid && !st_ready;
            heldData  = st_data;
            heldSop   = st_sop;
            heldEop   = st_eop;
            if (stopAfter >= 0 && popped == stopAfter) return;
        end
        checkOutput("done_seen", 32'(sawDone), 32'd1);
        checkOutput("issue_count", 32'(issued), 32'(len));
        checkOutput("pop_count", 32'(popped), 32'(len));
        if (len == 0) checkOutput("zero_len_no_valid", 32'(firstValidK < 0), 32'd1);
        if (len > 0 && mode == 0) checkOutput("first_valid_latency", 32'(firstValidK), 32'd2);
        @(negedge clk);
        checkOutput("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        int          addr;
        int          len;
        int          mode;
        logic [15:0] expFirst;
        logic [15:0] expLast;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic [15:0] fd, ld;

        vecs[0] = '{addr: 10,    len: 4,  mode: 0, expFirst: 16'hA00A, expLast: 16'hA00D};
        vecs[1] = '{addr: 14998, len: 4,  mode: 0, expFirst: 16'hDA96, expLast: 16'hA001};
        vecs[2] = '{addr: 0,     len: 10, mode: 1, expFirst: 16'hA000, expLast: 16'hA009};
        vecs[3] = '{addr: 5,     len: 0,  mode: 0, expFirst: 16'h0000, expLast: 16'h0000};
        vecs[4] = '{addr: 50,    len: 1,  mode: 2, expFirst: 16'hA032, expLast: 16'hA032};
        vecs[5] = '{addr: 14999, len: 3,  mode: 1, expFirst: 16'hDA97, expLast: 16'hA001};

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'hA000 + 16'(i);

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        st_ready  = 1'b0;
        #12;
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset_chipselect", 32'(mem_chipselect), 32'd0);
        checkOutput("reset_address", 32'(mem_address), 32'd0);
        checkOutput("reset_st_valid", 32'(st_valid), 32'd0);
        checkOutput("reset_sop_eop", 32'({st_sop, st_eop}), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("tie_offs", 32'({mem_clken, mem_write, mem_byteenable}), 32'b1011);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].mode, -1, fd, ld);
            if (vecs[i].len > 0) begin
                checkOutput("vec_first_word", 32'(fd), 32'(vecs[i].expFirst));
                checkOutput("vec_last_word", 32'(ld), 32'(vecs[i].expLast));
            end
        end

`ifdef DIRCC_MEM_READER_CHECKSUM_EN
        mem[200] = 16'h1234;
        mem[201] = 16'h00FF;
        mem[202] = 16'hF0F0;
        applyStimulus(200, 3, 0, -1, fd, ld);
        mem[200] = 16'hA0C8;
        mem[201] = 16'hA0C9;
        mem[202] = 16'hA0CA;
`endif

        // Reset in the middle of an 8-word packet, then a clean 2-word packet.
        applyStimulus(100, 8, 0, 3, fd, ld);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_st_valid", 32'(st_valid), 32'd0);
        checkOutput("midreset_chipselect", 32'(mem_chipselect), 32'd0);
        checkOutput("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        applyStimulus(0, 2, 0, -1, fd, ld);
        checkOutput("post_reset_first", 32'(fd), 32'hA000);
        checkOutput("post_reset_last", 32'(ld), 32'hA001);

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 20; i++) begin
            int a, l;
            a = (i % 4 == 0) ? (MEM_WORDS - 1 - int'($urandom_range(0, 5))) : int'($urandom_range(0, MEM_WORDS - 1));
            l = int'($urandom_range(0, 20));
            applyStimulus(a, l, (i % 3 == 0) ? 1 : 2, -1, fd, ld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dircc_processing_mem_reader.md
Name: dircc_processing_mem_reader

Overview:
- Avalon-MM read master for the 16-bit second port of a node's dual-port processing memory.
- Accepts a command (start halfword address, length) from the node's message logic and fetches that many halfwords.
- Emits the fetched data as an Avalon-ST packet with start-of-packet and end-of-packet markers.
- Sits between the processing memory and the node's outbound message router; it is the consumer-side counterpart of the CPU writing messages through the 32-bit port.

Parameters:
- MEM_WORDS, 15000, number of 16-bit words in the memory; the address wraps at this value.
- ADDR_W, 14, halfword address width.
- LEN_W, 8, width of the command length field, in halfwords.
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_addr  in  ADDR_W  first halfword address; must be less than MEM_WORDS
- cmd_len  in  LEN_W  number of halfwords to read; 0 is legal
- mem_address  out  ADDR_W  memory port address
- mem_chipselect  out  1  memory port select (read strobe)
- mem_clken  out  1  memory port clock enable; tied to 1
- mem_write  out  1  tied to 0
- mem_byteenable  out  2  tied to 2'b11
- mem_readdata  in  16  read data; valid exactly 1 cycle after the chipselect cycle
- st_valid  out  1  stream data valid
- st_ready  in  1  downstream ready
- st_data  out  16  stream data
- st_sop  out  1  first word of packet
- st_eop  out  1  last word of packet
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - State goes to IDLE; FIFO, counters and any in-flight read are discarded.
  - Outputs: cmd_ready=0 while reset is asserted, then 1 on the first cycle after release; mem_chipselect=0; mem_address=0; st_valid=0; st_sop=0; st_eop=0; done=0.
- IDLE:
  - cmd_ready=1. A command is accepted when cmd_valid and cmd_ready are both 1; the block latches the address and length.
  - cmd_len=0: no memory access and no stream output; done pulses on the next cycle; the block stays in IDLE with cmd_ready=1 after the pulse.
  - cmd_len>0: go to READ.
- READ:
  - One read is issued per cycle (mem_chipselect=1) while issued-but-unconsumed words (in flight + FIFO occupancy) are fewer than FIFO_DEPTH. This guarantees the FIFO never overflows when st_ready=0.
  - mem_readdata is captured into the FIFO in the cycle after each chipselect.
  - After each issue, the address increments; MEM_WORDS-1 wraps to 0.
  - After the last issue, go to DRAIN.
- DRAIN: no reads are issued. When the last word is popped, done=1 for that cycle and the state returns to IDLE.
- Stream output:
  - st_valid=1 whenever the FIFO is non-empty. A word is popped when st_valid and st_ready are both 1.
  - st_data, st_sop and st_eop are held stable while st_valid=1 and st_ready=0.
  - st_sop=1 on word 0 of the packet; st_eop=1 on word cmd_len-1. For cmd_len=1 both are 1 on the same word.
- Throughput: with st_ready held at 1, the first st_valid appears 2 cycles after command acceptance, then one word per cycle.
- FIFO push and pop in the same cycle are both allowed; occupancy is unchanged.
- cmd_ready=0 in READ and DRAIN; cmd_valid is ignored in those states.

Optional Feature:
- Macro: DIRCC_MEM_READER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (16 bits).
  - checksum is the XOR of all words popped in the current packet.
  - It is updated on each pop, cleared to 0 on command acceptance, and its final value is valid in the done cycle.
  - It holds that value until the next command is accepted. Reset value is 0.
  - For cmd_len=0 the value is 0.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Memory preloaded with mem[i]=16'hA000+i; cmd addr=10, len=4, st_ready=1 -> stream 0xA00A, 0xA00B, 0xA00C, 0xA00D; sop on the first word, eop on the last; done pulses with the last pop; 4 chipselect cycles in total.
- Wrap: cmd addr=14998, len=4 -> addresses issued 14998, 14999, 0, 1; data matches mem at those addresses.
- Backpressure: len=10, st_ready toggling 1-0-0-1 repeatedly -> all 10 words delivered in order with none lost or duplicated; outstanding reads never exceed 4; data is stable during stalls.
- cmd_len=0 -> no chipselect and no st_valid; done pulses 1 cycle after acceptance; cmd_ready=1 on the next cycle.
- Reset mid-packet: reset_n=0 after 3 of 8 words -> st_valid=0 and mem_chipselect=0 immediately; no done; after release, a new cmd (addr=0, len=2) produces a clean sop/eop packet.
- Checksum (macro defined): words 0x1234, 0x00FF, 0xF0F0 -> checksum=0xE23B in the done cycle.
